// File: rtl/risc_v_multicycle.sv
// risc_v_multicycle: multi-cycle RV32I-subset core with one shared
// instruction/data memory port using a req/ready handshake.
//
// Ports:
//   clk, rst_n        rising-edge clock, asynchronous active-low reset
//   mem_req           memory request valid
//   mem_we            1 = write, 0 = read (valid while mem_req)
//   mem_addr          word-aligned byte address (low ADDR_W bits)
//   mem_wdata         store data
//   mem_rdata         read data, sampled when mem_req & mem_ready
//   mem_ready         completes the current request
//   pc_o              PC of the instruction in progress
//   retire            one-cycle pulse when an instruction commits
//   halt              core trapped; sticky until reset
//
// Supported: lw, sw, add, sub, and, or, slt, addi, andi, ori, slti, beq, jal.
module risc_v_multicycle #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          ADDR_W   = 32,
  parameter int          REG_CNT  = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata,
  input  logic              mem_ready,
  output logic [31:0]       pc_o,
  output logic              retire,
  output logic              halt
);

  if (REG_CNT != 32 && REG_CNT != 16) begin : g_bad_regcnt
    $error("risc_v_multicycle: REG_CNT must be 32 or 16");
  end
  if (ADDR_W < 3 || ADDR_W > 32) begin : g_bad_addrw
    $error("risc_v_multicycle: ADDR_W must be in 3..32");
  end

  localparam int RI = (REG_CNT == 16) ? 4 : 5;

  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_I   = 7'b0010011;
  localparam logic [6:0] OP_LW  = 7'b0000011;
  localparam logic [6:0] OP_SW  = 7'b0100011;
  localparam logic [6:0] OP_BR  = 7'b1100011;
  localparam logic [6:0] OP_JAL = 7'b1101111;

  typedef enum logic [3:0] {
    S_FETCH, S_DECODE, S_EXEC, S_ALUWB, S_MEMADDR, S_MEMRD,
    S_MEMWB, S_MEMWR, S_BRANCH, S_JAL, S_TRAP
  } state_e;

  state_e             state_q, state_d;
  logic [31:0]        pc_q, pc_d;
  logic               req_q, req_d;
  logic               we_q, we_d;
  logic [ADDR_W-1:0]  addr_q, addr_d;
  logic [31:0]        wdata_q, wdata_d;
  logic [31:0]        rf_q [REG_CNT];

  // Datapath holding registers (no reset: always written before use)
  logic [31:0] ir_q, a_q, b_q, imm_q, pc4_q, tgt_q, res_q, mdr_q;

  logic          rf_we;
  logic [RI-1:0] rf_waddr;
  logic [31:0]   rf_wdata;
  logic [31:0]   npc;
  logic          next_fetch;

  // Instruction fields
  logic [6:0] opc, f7;
  logic [2:0] f3;
  logic [4:0] rd_f, rs1_f, rs2_f;
  assign opc   = ir_q[6:0];
  assign rd_f  = ir_q[11:7];
  assign f3    = ir_q[14:12];
  assign rs1_f = ir_q[19:15];
  assign rs2_f = ir_q[24:20];
  assign f7    = ir_q[31:25];

  function automatic logic reg_ok(input logic [4:0] f);
    return (REG_CNT == 32) || !f[4];
  endfunction

  // Decode: legality and which register fields the instruction really uses
  logic legal, use_rd, use_rs1, use_rs2, regs_ok;
  always_comb begin
    legal   = 1'b0;
    use_rd  = 1'b0;
    use_rs1 = 1'b0;
    use_rs2 = 1'b0;
    case (opc)
      OP_R: begin
        legal   = (f7 == 7'h00 && (f3 == 3'b000 || f3 == 3'b111 ||
                                   f3 == 3'b110 || f3 == 3'b010)) ||
                  (f7 == 7'h20 && f3 == 3'b000);
        use_rd  = 1'b1;
        use_rs1 = 1'b1;
        use_rs2 = 1'b1;
      end
      OP_I: begin
        legal   = (f3 == 3'b000 || f3 == 3'b111 || f3 == 3'b110 || f3 == 3'b010);
        use_rd  = 1'b1;
        use_rs1 = 1'b1;
      end
      OP_LW: begin
        legal   = (f3 == 3'b010);
        use_rd  = 1'b1;
        use_rs1 = 1'b1;
      end
      OP_SW: begin
        legal   = (f3 == 3'b010);
        use_rs1 = 1'b1;
        use_rs2 = 1'b1;
      end
      OP_BR: begin
        legal   = (f3 == 3'b000);
        use_rs1 = 1'b1;
        use_rs2 = 1'b1;
      end
      OP_JAL: begin
        legal   = 1'b1;
        use_rd  = 1'b1;
      end
      default: ;
    endcase
  end
  assign regs_ok = (!use_rd  || reg_ok(rd_f)) &&
                   (!use_rs1 || reg_ok(rs1_f)) &&
                   (!use_rs2 || reg_ok(rs2_f));

  // Immediates, all sign-extended
  logic [31:0] imm_i, imm_s, imm_b, imm_j, imm;
  assign imm_i = {{20{ir_q[31]}}, ir_q[31:20]};
  assign imm_s = {{20{ir_q[31]}}, ir_q[31:25], ir_q[11:7]};
  assign imm_b = {{19{ir_q[31]}}, ir_q[31], ir_q[7], ir_q[30:25], ir_q[11:8], 1'b0};
  assign imm_j = {{11{ir_q[31]}}, ir_q[31], ir_q[19:12], ir_q[20], ir_q[30:21], 1'b0};
  always_comb begin
    case (opc)
      OP_SW:   imm = imm_s;
      OP_BR:   imm = imm_b;
      OP_JAL:  imm = imm_j;
      default: imm = imm_i;
    endcase
  end

  // Register read; x0 is never written so it always reads 0
  logic [31:0] rs1v, rs2v;
  assign rs1v = rf_q[rs1_f[RI-1:0]];
  assign rs2v = rf_q[rs2_f[RI-1:0]];

  // ALU (operates on latched operands during EXEC)
  logic [31:0]        op2, alu, ea;
  logic signed [31:0] a_s, op2_s;
  assign op2   = (opc == OP_R) ? b_q : imm_q;
  assign a_s   = a_q;
  assign op2_s = op2;
  always_comb begin
    case (f3)
      3'b000:  alu = (opc == OP_R && f7[5]) ? (a_q - op2) : (a_q + op2);
      3'b111:  alu = a_q & op2;
      3'b110:  alu = a_q | op2;
      3'b010:  alu = {31'd0, (a_s < op2_s)};
      default: alu = a_q + op2;
    endcase
  end
  assign ea = a_q + imm_q;

  // Next-state and outputs
  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    req_d      = req_q;
    we_d       = we_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    rf_we      = 1'b0;
    rf_waddr   = rd_f[RI-1:0];
    rf_wdata   = res_q;
    retire     = 1'b0;
    npc        = pc_q;
    next_fetch = 1'b0;
    case (state_q)
      S_FETCH: begin
        if (!req_q) begin
          // Only reachable straight out of reset: issue the first fetch
          npc        = pc_q;
          next_fetch = 1'b1;
        end else if (mem_ready) begin
          req_d   = 1'b0;
          state_d = S_DECODE;
        end
      end
      S_DECODE: begin
        if (!legal || !regs_ok) begin
          state_d = S_TRAP;
        end else begin
          case (opc)
            OP_LW, OP_SW: state_d = S_MEMADDR;
            OP_BR:        state_d = S_BRANCH;
            OP_JAL:       state_d = S_JAL;
            default:      state_d = S_EXEC;
          endcase
        end
      end
      S_EXEC: state_d = S_ALUWB;
      S_ALUWB: begin
        rf_we      = 1'b1;
        rf_wdata   = res_q;
        retire     = 1'b1;
        npc        = pc4_q;
        next_fetch = 1'b1;
      end
      S_MEMADDR: begin
        if (ea[1:0] != 2'b00) begin
          state_d = S_TRAP;
        end else begin
          req_d   = 1'b1;
          we_d    = (opc == OP_SW);
          addr_d  = ea[ADDR_W-1:0];
          wdata_d = b_q;
          state_d = (opc == OP_SW) ? S_MEMWR : S_MEMRD;
        end
      end
      S_MEMRD: begin
        if (mem_ready) begin
          req_d   = 1'b0;
          state_d = S_MEMWB;
        end
      end
      S_MEMWB: begin
        rf_we      = 1'b1;
        rf_wdata   = mdr_q;
        retire     = 1'b1;
        npc        = pc4_q;
        next_fetch = 1'b1;
      end
      S_MEMWR: begin
        if (mem_ready) begin
          retire     = 1'b1;
          npc        = pc4_q;
          next_fetch = 1'b1;
        end
      end
      S_BRANCH: begin
        retire     = 1'b1;
        npc        = (a_q == b_q) ? tgt_q : pc4_q;
        next_fetch = 1'b1;
      end
      S_JAL: begin
        rf_we      = 1'b1;
        rf_wdata   = pc4_q;
        retire     = 1'b1;
        npc        = tgt_q;
        next_fetch = 1'b1;
      end
      default: ; // S_TRAP: frozen until reset
    endcase

    // Launching a fetch is registered so mem_req rises on the same edge the
    // previous instruction commits; a misaligned PC traps without a request.
    if (next_fetch) begin
      pc_d = npc;
      we_d = 1'b0;
      if (npc[1:0] != 2'b00) begin
        state_d = S_TRAP;
        req_d   = 1'b0;
      end else begin
        state_d = S_FETCH;
        req_d   = 1'b1;
        addr_d  = npc[ADDR_W-1:0];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_FETCH;
      pc_q    <= RESET_PC;
      req_q   <= 1'b0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      for (int i = 0; i < REG_CNT; i++) rf_q[i] <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      req_q   <= req_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      if (rf_we && rf_waddr != '0) rf_q[rf_waddr] <= rf_wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (state_q == S_FETCH && req_q && mem_ready) ir_q <= mem_rdata;
    if (state_q == S_DECODE) begin
      a_q   <= rs1v;
      b_q   <= rs2v;
      imm_q <= imm;
      pc4_q <= pc_q + 32'd4;
      tgt_q <= pc_q + imm;
    end
    if (state_q == S_EXEC) res_q <= alu;
    if (state_q == S_MEMRD && mem_ready) mdr_q <= mem_rdata;
  end

  assign mem_req   = req_q;
  assign mem_we    = we_q;
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;
  assign pc_o      = pc_q;
  assign halt      = (state_q == S_TRAP);

endmodule

// File: tb/tb_risc_v_multicycle.sv
module tb_risc_v_multicycle;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        mem_req, mem_we, mem_ready;
  logic [31:0] mem_addr, mem_wdata, mem_rdata, pc_o;
  logic        retire, halt;

  logic        rst2_n = 1'b0;
  logic        req2, we2, retire2, halt2;
  logic [31:0] addr2, wdata2, rdata2, pc2;

  int vectors = 0;
  int miscompares = 0;

  // Memory model for the main core: program image plus written-data overlay
  logic [31:0]  prog  [256];
  logic [31:0]  dmem  [256];
  logic [255:0] dvld = '0;
  logic         clr = 1'b0;
  int           waits = 0;
  int           wcnt = 0;
  int           retire_cnt = 0;
  int           wr_cnt = 0;
  logic [31:0]  last_wr_addr = '0, last_wr_data = '0;
  logic [7:0]   ridx;

  logic [31:0] prog2 [256];
  int          retire2_cnt = 0;

  int          stab_err = 0;
  logic        chk_prev = 1'b0;
  logic [31:0] p_addr = '0, p_wdata = '0;
  logic        p_we = 1'b0;

  always #5 clk = ~clk;

  risc_v_multicycle dut (
    .clk(clk), .rst_n(rst_n),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ready(mem_ready),
    .pc_o(pc_o), .retire(retire), .halt(halt)
  );

  risc_v_multicycle #(.REG_CNT(16)) dut2 (
    .clk(clk), .rst_n(rst2_n),
    .mem_req(req2), .mem_we(we2), .mem_addr(addr2),
    .mem_wdata(wdata2), .mem_rdata(rdata2), .mem_ready(1'b1),
    .pc_o(pc2), .retire(retire2), .halt(halt2)
  );

  assign ridx      = mem_addr[9:2];
  assign mem_rdata = dvld[ridx] ? dmem[ridx] : prog[ridx];
  assign mem_ready = (waits == 0) ? 1'b1 : (mem_req && (wcnt == waits));
  assign rdata2    = prog2[addr2[9:2]];

  always @(posedge clk) begin
    if (mem_req && !mem_ready) wcnt <= wcnt + 1;
    else wcnt <= 0;
    if (retire) retire_cnt <= retire_cnt + 1;
    if (retire2) retire2_cnt <= retire2_cnt + 1;
    if (clr) dvld <= '0;
    else if (mem_req && mem_ready && mem_we) begin
      dmem[ridx]   <= mem_wdata;
      dvld[ridx]   <= 1'b1;
      wr_cnt       <= wr_cnt + 1;
      last_wr_addr <= mem_addr;
      last_wr_data <= mem_wdata;
    end
  end

  // Request attributes must not move while a request is waiting
  always @(negedge clk) begin
    if (chk_prev && mem_req &&
        (mem_addr !== p_addr || mem_we !== p_we || mem_wdata !== p_wdata))
      stab_err <= stab_err + 1;
    chk_prev <= mem_req && !mem_ready;
    p_addr   <= mem_addr;
    p_we     <= mem_we;
    p_wdata  <= mem_wdata;
  end

  function automatic logic [31:0] enc_i(input logic [11:0] imm, input logic [4:0] rs1,
                                        input logic [2:0] f3, input logic [4:0] rd,
                                        input logic [6:0] op);
    return {imm, rs1, f3, rd, op};
  endfunction
  function automatic logic [31:0] enc_r(input logic [6:0] f7, input logic [4:0] rs2,
                                        input logic [4:0] rs1, input logic [2:0] f3,
                                        input logic [4:0] rd);
    return {f7, rs2, rs1, f3, rd, 7'h33};
  endfunction
  function automatic logic [31:0] enc_s(input logic [11:0] imm, input logic [4:0] rs2,
                                        input logic [4:0] rs1);
    return {imm[11:5], rs2, rs1, 3'b010, imm[4:0], 7'h23};
  endfunction
  function automatic logic [31:0] enc_b(input logic [12:0] imm, input logic [4:0] rs2,
                                        input logic [4:0] rs1);
    return {imm[12], imm[10:5], rs2, rs1, 3'b000, imm[4:1], imm[11], 7'h63};
  endfunction
  function automatic logic [31:0] enc_j(input logic [20:0] imm, input logic [4:0] rd);
    return {imm[20], imm[10:1], imm[11], imm[19:12], rd, 7'h6F};
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp)
    else begin
      miscompares++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic clear_prog();
    for (int i = 0; i < 256; i++) prog[i] = 32'h0;
  endtask

  // Leaves the bench at the negedge of the first fetch cycle
  task automatic do_reset();
    rst_n = 1'b0;
    clr   = 1'b1;
    repeat (2) @(negedge clk);
    clr   = 1'b0;
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  // Counts cycles from the current fetch cycle up to the retire cycle,
  // then steps to the next instruction's first cycle
  task automatic run_instr(output int cyc);
    cyc = 1;
    while (!retire && cyc < 64) begin
      @(negedge clk);
      cyc++;
    end
    @(negedge clk);
  endtask

  task automatic wait_halt();
    for (int i = 0; i < 300 && !halt; i++) @(negedge clk);
    check("halt_reached", halt, 1);
  endtask

  int cyc, r0, w0, req_seen, found;

  initial begin
    // ---- Reset state and first instruction ----
    waits = 0;
    clear_prog();
    prog[0] = enc_i(12'd5, 5'd0, 3'b000, 5'd1, 7'h13);          // addi x1,x0,5
    rst_n = 1'b0;
    clr   = 1'b1;
    repeat (2) @(negedge clk);
    check("rst_req", mem_req, 0);
    check("rst_we", mem_we, 0);
    check("rst_addr", mem_addr, 0);
    check("rst_wdata", mem_wdata, 0);
    check("rst_retire", retire, 0);
    check("rst_halt", halt, 0);
    check("rst_pc", pc_o, 32'h0);
    check("rst_x1", dut.rf_q[1], 0);
    clr   = 1'b0;
    rst_n = 1'b1;
    @(negedge clk);
    check("first_req", mem_req, 1);
    check("first_addr", mem_addr, 32'h0);
    check("first_we", mem_we, 0);
    run_instr(cyc);
    check("addi_cycles", cyc, 4);
    check("addi_x1", dut.rf_q[1], 5);
    check("addi_pc", pc_o, 32'h4);

    // ---- Branch skip, store and load, zero-wait ----
    clear_prog();
    prog[0] = enc_i(12'd7, 5'd0, 3'b000, 5'd1, 7'h13);          // addi x1,x0,7
    prog[1] = enc_i(12'd7, 5'd0, 3'b000, 5'd2, 7'h13);          // addi x2,x0,7
    prog[2] = enc_b(13'd8, 5'd2, 5'd1);                         // beq x1,x2,+8
    prog[3] = enc_i(12'd1, 5'd0, 3'b000, 5'd3, 7'h13);          // addi x3,x0,1
    prog[4] = enc_s(12'h040, 5'd1, 5'd0);                       // sw x1,0x40(x0)
    prog[5] = enc_i(12'h040, 5'd0, 3'b010, 5'd4, 7'h03);        // lw x4,0x40(x0)
    do_reset();
    r0 = retire_cnt;
    w0 = wr_cnt;
    run_instr(cyc); check("p2_addi1_cycles", cyc, 4);
    run_instr(cyc); check("p2_addi2_cycles", cyc, 4);
    run_instr(cyc); check("p2_beq_cycles", cyc, 3);
    check("p2_beq_target", pc_o, 32'h10);
    run_instr(cyc); check("p2_sw_cycles", cyc, 4);
    run_instr(cyc); check("p2_lw_cycles", cyc, 5);
    repeat (4) @(negedge clk);
    check("p2_halt", halt, 1);
    check("p2_halt_pc", pc_o, 32'h18);
    check("p2_halt_req", mem_req, 0);
    check("p2_retires", retire_cnt - r0, 5);
    check("p2_writes", wr_cnt - w0, 1);
    check("p2_wr_addr", last_wr_addr, 32'h40);
    check("p2_wr_data", last_wr_data, 32'h7);
    check("p2_x3", dut.rf_q[3], 0);
    check("p2_x4", dut.rf_q[4], 7);

    // ---- ALU operations with signed operands, untaken branch ----
    clear_prog();
    prog[0]  = enc_i(12'hFFD, 5'd0, 3'b000, 5'd1, 7'h13);       // addi x1,x0,-3
    prog[1]  = enc_i(12'd5, 5'd0, 3'b000, 5'd2, 7'h13);         // addi x2,x0,5
    prog[2]  = enc_r(7'h20, 5'd2, 5'd1, 3'b000, 5'd3);          // sub x3,x1,x2
    prog[3]  = enc_r(7'h00, 5'd2, 5'd1, 3'b111, 5'd4);          // and x4,x1,x2
    prog[4]  = enc_r(7'h00, 5'd2, 5'd1, 3'b110, 5'd5);          // or  x5,x1,x2
    prog[5]  = enc_r(7'h00, 5'd2, 5'd1, 3'b010, 5'd6);          // slt x6,x1,x2
    prog[6]  = enc_i(12'hFFF, 5'd2, 3'b010, 5'd7, 7'h13);       // slti x7,x2,-1
    prog[7]  = enc_i(12'h0F0, 5'd1, 3'b111, 5'd8, 7'h13);       // andi x8,x1,0xF0
    prog[8]  = enc_i(12'h100, 5'd2, 3'b110, 5'd9, 7'h13);       // ori x9,x2,0x100
    prog[9]  = enc_r(7'h00, 5'd2, 5'd1, 3'b000, 5'd10);         // add x10,x1,x2
    prog[10] = enc_b(13'd8, 5'd2, 5'd1);                        // beq x1,x2,+8 (not taken)
    prog[11] = enc_i(12'd9, 5'd0, 3'b000, 5'd11, 7'h13);        // addi x11,x0,9
    do_reset();
    wait_halt();
    check("alu_sub", dut.rf_q[3], 32'hFFFF_FFF8);
    check("alu_and", dut.rf_q[4], 32'h0000_0005);
    check("alu_or", dut.rf_q[5], 32'hFFFF_FFFD);
    check("alu_slt", dut.rf_q[6], 32'h1);
    check("alu_slti", dut.rf_q[7], 32'h0);
    check("alu_andi", dut.rf_q[8], 32'h0000_00F0);
    check("alu_ori", dut.rf_q[9], 32'h0000_0105);
    check("alu_add", dut.rf_q[10], 32'h2);
    check("beq_not_taken", dut.rf_q[11], 32'h9);
    check("alu_halt_pc", pc_o, 32'h30);

    // ---- Three wait states on every access ----
    waits = 3;
    clear_prog();
    prog[0] = enc_i(12'd7, 5'd0, 3'b000, 5'd1, 7'h13);          // addi x1,x0,7
    prog[1] = enc_s(12'h040, 5'd1, 5'd0);                       // sw x1,0x40(x0)
    prog[2] = enc_i(12'h040, 5'd0, 3'b010, 5'd5, 7'h03);        // lw x5,0x40(x0)
    do_reset();
    r0 = retire_cnt;
    check("ws_first_ready", mem_ready, 0);
    run_instr(cyc); check("ws_addi_cycles", cyc, 7);
    run_instr(cyc); check("ws_sw_cycles", cyc, 10);
    run_instr(cyc); check("ws_lw_cycles", cyc, 11);
    repeat (8) @(negedge clk);
    check("ws_retires", retire_cnt - r0, 3);
    check("ws_x5", dut.rf_q[5], 7);
    check("ws_stable", stab_err, 0);
    check("ws_halt", halt, 1);

    // ---- jal, then misaligned load traps ----
    waits = 0;
    clear_prog();
    prog[0]  = enc_j(21'h100, 5'd0);                            // jal x0,+0x100
    prog[64] = enc_j(21'd16, 5'd1);                             // jal x1,+16 @0x100
    prog[68] = enc_i(12'd2, 5'd0, 3'b010, 5'd5, 7'h03);         // lw x5,2(x0) @0x110
    do_reset();
    run_instr(cyc); check("jal0_cycles", cyc, 3);
    check("jal0_pc", pc_o, 32'h100);
    run_instr(cyc); check("jal1_cycles", cyc, 3);
    check("jal1_x1", dut.rf_q[1], 32'h104);
    check("jal1_fetch_addr", mem_addr, 32'h110);
    check("jal1_fetch_req", mem_req, 1);
    r0 = retire_cnt;
    repeat (4) @(negedge clk);
    check("mis_halt", halt, 1);
    check("mis_pc", pc_o, 32'h110);
    req_seen = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (mem_req) req_seen++;
    end
    check("mis_req_quiet", req_seen, 0);
    check("mis_no_retire", retire_cnt - r0, 0);
    check("mis_x5", dut.rf_q[5], 0);
    check("mis_halt_sticky", halt, 1);

    // ---- REG_CNT=16 core: legal, out-of-range rd, illegal opcode ----
    for (int i = 0; i < 256; i++) prog2[i] = 32'h0;
    prog2[0] = enc_i(12'd3, 5'd0, 3'b000, 5'd5, 7'h13);         // addi x5,x0,3
    rst2_n = 1'b0;
    @(negedge clk);
    rst2_n = 1'b1;
    repeat (10) @(negedge clk);
    check("rc16_x5", dut2.rf_q[5], 3);
    check("rc16_ok_halt_pc", pc2, 32'h4);
    prog2[0] = enc_i(12'd1, 5'd0, 3'b000, 5'd20, 7'h13);        // addi x20,x0,1
    rst2_n = 1'b0;
    @(negedge clk);
    r0 = retire2_cnt;
    rst2_n = 1'b1;
    repeat (10) @(negedge clk);
    check("rc16_halt", halt2, 1);
    check("rc16_pc", pc2, 32'h0);
    check("rc16_req", req2, 0);
    check("rc16_no_retire", retire2_cnt - r0, 0);
    check("rc16_x4_untouched", dut2.rf_q[4], 0);
    prog2[0] = 32'h0000_007F;
    rst2_n = 1'b0;
    @(negedge clk);
    check("rc16_rst_halt", halt2, 0);
    rst2_n = 1'b1;
    repeat (10) @(negedge clk);
    check("illegal_halt", halt2, 1);

    // ---- Reset while a load is waiting ----
    waits = 3;
    clear_prog();
    prog[0]  = enc_i(12'd5, 5'd0, 3'b000, 5'd1, 7'h13);         // addi x1,x0,5
    prog[1]  = enc_i(12'h040, 5'd0, 3'b010, 5'd6, 7'h03);       // lw x6,0x40(x0)
    prog[16] = 32'd9;
    do_reset();
    run_instr(cyc);
    check("mr_x1_before", dut.rf_q[1], 5);
    found = 0;
    for (int i = 0; i < 30; i++) begin
      if (mem_req && !mem_we && mem_addr == 32'h40) begin
        found = 1;
        break;
      end
      @(negedge clk);
    end
    check("mr_load_seen", found, 1);
    rst_n = 1'b0;
    #1;
    check("mr_req_drop", mem_req, 0);
    check("mr_addr_zero", mem_addr, 0);
    check("mr_x1_cleared", dut.rf_q[1], 0);
    check("mr_pc", pc_o, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("mr_refetch_req", mem_req, 1);
    check("mr_refetch_addr", mem_addr, 32'h0);
    check("mr_x6", dut.rf_q[6], 0);
    run_instr(cyc);
    check("mr_addi_cycles", cyc, 7);
    check("mr_x1_after", dut.rf_q[1], 5);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
